// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer
// and its multiply/divide start/busy sequencer.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        MDU_NONE = 2'b00,
        MDU_MUL  = 2'b01,
        MDU_DIV  = 2'b10,
        MDU_HILO = 2'b11
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    localparam int DEF_MULT_CYCLES = 4;
    localparam int DEF_DIV_CYCLES  = 32;

endpackage

// File: rtl/pipeline_hazard_ctrl_mdu_sequencer.sv
// MDU start/busy sequencer: a start loads the op latency into a down-counter,
// and MduBusy holds until the counter reaches its terminal count of 1.
//
// state | meaning
// IDLE  | no MDU result pending; a start may be accepted
// BUSY  | result pending; counter decrements every cycle, even during stalls
module mdu_sequencer
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_is_div,
    output logic o_busy
);

    localparam logic [CNT_W-1:0] L_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] L_DIV  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);

    mdu_state_e       r_state, w_next_state;
    logic [CNT_W-1:0] r_count, w_next_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next_state = BUSY;
                    w_next_count = i_is_div ? L_DIV : L_MULT;
                end
            end
            BUSY: begin
                w_next_count = r_count - L_ONE;
                if (r_count == L_ONE) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign o_busy = (r_state == BUSY);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch-after-load,
// MDU-busy and data-memory wait hazards, plus a stall-cycle counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  RegSource_ID,
    input  logic [4:0]  RegTarget_ID,
    input  logic        UsesRs_ID,
    input  logic        UsesRt_ID,
    input  logic        BranchOp_ID,
    input  logic        BranchTaken_ID,
    input  logic [1:0]  MduOp_ID,
    input  logic [2:0]  MemRead_EX,
    input  logic [2:0]  MemRead_MEM,
    input  logic [4:0]  WriteRegAddr_EX,
    input  logic [4:0]  WriteRegAddr_MEM,
    input  logic        DmemReq_MEM,
    input  logic        DmemReady,
    output logic        PcWrite,
    output logic        IfIdWrite,
    output logic        IdExWrite,
    output logic        ExMemWrite,
    output logic        MemWbWrite,
    output logic        IfIdFlush,
    output logic        IdExFlush,
    output logic        MemWbFlush,
    output logic        MduStart,
    output logic        MduBusy,
    output logic [31:0] StallCycles
);

    logic        w_mem_stall;
    logic        w_mdu_stall;
    logic        w_load_use;
    logic        w_br_load;
    logic        w_id_stall;
    logic        w_mdu_busy;
    logic        w_mdu_issue;
    logic [31:0] r_stall_cycles;

    assign w_mem_stall = DmemReq_MEM & ~DmemReady;
    assign w_mdu_stall = w_mdu_busy & (MduOp_ID != MDU_NONE);

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign w_load_use = (MemRead_EX != 3'd0) && (WriteRegAddr_EX != 5'd0) &&
                        ((UsesRs_ID && (RegSource_ID == WriteRegAddr_EX)) ||
                         (UsesRt_ID && (RegTarget_ID == WriteRegAddr_EX)));

    assign w_br_load  = BranchOp_ID && (MemRead_MEM != 3'd0) && (WriteRegAddr_MEM != 5'd0) &&
                        ((UsesRs_ID && (RegSource_ID == WriteRegAddr_MEM)) ||
                         (UsesRt_ID && (RegTarget_ID == WriteRegAddr_MEM)));

    assign w_id_stall = w_mdu_stall | w_load_use | w_br_load;

    always_comb begin
        PcWrite    = 1'b1;
        IfIdWrite  = 1'b1;
        IdExWrite  = 1'b1;
        ExMemWrite = 1'b1;
        MemWbWrite = 1'b1;
        IfIdFlush  = 1'b0;
        IdExFlush  = 1'b0;
        MemWbFlush = 1'b0;
        if (w_mem_stall) begin
            PcWrite    = 1'b0;
            IfIdWrite  = 1'b0;
            IdExWrite  = 1'b0;
            ExMemWrite = 1'b0;
            MemWbWrite = 1'b0;
            MemWbFlush = 1'b1;
        end else if (w_id_stall) begin
            PcWrite    = 1'b0;
            IfIdWrite  = 1'b0;
            IdExFlush  = 1'b1;
        end else if (BranchTaken_ID) begin
            IfIdFlush  = 1'b1;
        end
    end

    // An MDU op is issued only in the cycle it actually advances into EX.
    assign w_mdu_issue = ((MduOp_ID == MDU_MUL) || (MduOp_ID == MDU_DIV)) &&
                         IdExWrite && !IdExFlush && !w_mdu_busy;
    assign MduStart    = w_mdu_issue;
    assign MduBusy     = w_mdu_busy;

    mdu_sequencer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_mdu_sequencer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_mdu_issue),
        .i_is_div (MduOp_ID == MDU_DIV),
        .o_busy   (w_mdu_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (!PcWrite) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign StallCycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected control vectors are queued
// as each step is driven and popped/compared when the outputs are sampled.
module tb_pipeline_hazard_ctrl;

    localparam logic [7:0] NORM  = 8'b11111_000;
    localparam logic [7:0] STALL = 8'b00111_010;
    localparam logic [7:0] MEMST = 8'b00000_001;
    localparam logic [7:0] BRT   = 8'b11111_100;

    typedef struct packed {
        logic [7:0]  ctl;
        logic        start;
        logic        busy;
        logic [31:0] stalls;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  RegSource_ID, RegTarget_ID;
    logic        UsesRs_ID, UsesRt_ID, BranchOp_ID, BranchTaken_ID;
    logic [1:0]  MduOp_ID;
    logic [2:0]  MemRead_EX, MemRead_MEM;
    logic [4:0]  WriteRegAddr_EX, WriteRegAddr_MEM;
    logic        DmemReq_MEM, DmemReady;
    logic        PcWrite, IfIdWrite, IdExWrite, ExMemWrite, MemWbWrite;
    logic        IfIdFlush, IdExFlush, MemWbFlush, MduStart, MduBusy;
    logic [31:0] StallCycles;

    exp_t        exp_q[$];
    string       tag_q[$];
    int          n_cmp;
    int          n_fail;
    logic [31:0] exp_stalls;

    pipeline_hazard_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .RegSource_ID     (RegSource_ID),
        .RegTarget_ID     (RegTarget_ID),
        .UsesRs_ID        (UsesRs_ID),
        .UsesRt_ID        (UsesRt_ID),
        .BranchOp_ID      (BranchOp_ID),
        .BranchTaken_ID   (BranchTaken_ID),
        .MduOp_ID         (MduOp_ID),
        .MemRead_EX       (MemRead_EX),
        .MemRead_MEM      (MemRead_MEM),
        .WriteRegAddr_EX  (WriteRegAddr_EX),
        .WriteRegAddr_MEM (WriteRegAddr_MEM),
        .DmemReq_MEM      (DmemReq_MEM),
        .DmemReady        (DmemReady),
        .PcWrite          (PcWrite),
        .IfIdWrite        (IfIdWrite),
        .IdExWrite        (IdExWrite),
        .ExMemWrite       (ExMemWrite),
        .MemWbWrite       (MemWbWrite),
        .IfIdFlush        (IfIdFlush),
        .IdExFlush        (IdExFlush),
        .MemWbFlush       (MemWbFlush),
        .MduStart         (MduStart),
        .MduBusy          (MduBusy),
        .StallCycles      (StallCycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clr();
        RegSource_ID = 5'd0;  RegTarget_ID = 5'd0;
        UsesRs_ID = 1'b0;     UsesRt_ID = 1'b0;
        BranchOp_ID = 1'b0;   BranchTaken_ID = 1'b0;
        MduOp_ID = 2'b00;
        MemRead_EX = 3'd0;    MemRead_MEM = 3'd0;
        WriteRegAddr_EX = 5'd0; WriteRegAddr_MEM = 5'd0;
        DmemReq_MEM = 1'b0;   DmemReady = 1'b1;
    endtask

    task automatic push(input string tag, input logic [7:0] ctl, input logic start, input logic busy);
        exp_t e;
        e.ctl = ctl; e.start = start; e.busy = busy; e.stalls = exp_stalls;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_pop();
        exp_t        e;
        string       t;
        logic [7:0]  obs_ctl;
        logic [1:0]  obs_mdu;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_empty observed=0 entries expected>=1");
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        obs_ctl = {PcWrite, IfIdWrite, IdExWrite, ExMemWrite, MemWbWrite, IfIdFlush, IdExFlush, MemWbFlush};
        obs_mdu = {MduStart, MduBusy};
        n_cmp++;
        assert (obs_ctl === e.ctl) else begin
            n_fail++;
            $error("FAIL %s ctl observed=%b expected=%b", t, obs_ctl, e.ctl);
        end
        n_cmp++;
        assert (obs_mdu === {e.start, e.busy}) else begin
            n_fail++;
            $error("FAIL %s start/busy observed=%b expected=%b", t, obs_mdu, {e.start, e.busy});
        end
        n_cmp++;
        assert (StallCycles === e.stalls) else begin
            n_fail++;
            $error("FAIL %s StallCycles observed=%0d expected=%0d", t, StallCycles, e.stalls);
        end
    endtask

    // One clock: queue expectation, compare at the falling edge, advance past the rising edge.
    task automatic cyc(input string tag, input logic [7:0] ctl, input logic start, input logic busy);
        push(tag, ctl, start, busy);
        @(negedge clk);
        check_pop();
        @(posedge clk);
        if (rst_n && !ctl[7]) exp_stalls = exp_stalls + 32'd1;
        #1;
    endtask

    task automatic load_use_rs8();
        MemRead_EX = 3'b010; WriteRegAddr_EX = 5'd8;
        RegSource_ID = 5'd8; UsesRs_ID = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        exp_stalls = 32'd0;
        rst_n = 1'b0;
        clr();
        @(posedge clk); #1;
        cyc("reset", NORM, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc("idle", NORM, 1'b0, 1'b0);

        // lw $8 in EX, add using $8 in ID
        load_use_rs8();
        cyc("lu_stall", STALL, 1'b0, 1'b0);
        MemRead_EX = 3'd0; WriteRegAddr_EX = 5'd0;
        MemRead_MEM = 3'b010; WriteRegAddr_MEM = 5'd8;
        cyc("lu_release", NORM, 1'b0, 1'b0);

        clr();
        MemRead_EX = 3'b010; WriteRegAddr_EX = 5'd0; RegSource_ID = 5'd0; UsesRs_ID = 1'b1;
        cyc("reg0_nohaz", NORM, 1'b0, 1'b0);
        clr();
        MemRead_EX = 3'b001; WriteRegAddr_EX = 5'd9; RegTarget_ID = 5'd9;
        cyc("rt_unused", NORM, 1'b0, 1'b0);
        UsesRt_ID = 1'b1;
        cyc("rt_lu", STALL, 1'b0, 1'b0);

        // beq $8 after lw $8, taken: loadUse, then brLoad, then resolves
        clr();
        load_use_rs8();
        BranchOp_ID = 1'b1; BranchTaken_ID = 1'b1;
        cyc("br_lu", STALL, 1'b0, 1'b0);
        MemRead_EX = 3'd0; WriteRegAddr_EX = 5'd0;
        MemRead_MEM = 3'b010; WriteRegAddr_MEM = 5'd8;
        cyc("br_load", STALL, 1'b0, 1'b0);
        MemRead_MEM = 3'd0; WriteRegAddr_MEM = 5'd0;
        cyc("br_resolve", BRT, 1'b0, 1'b0);

        clr();
        BranchOp_ID = 1'b1; BranchTaken_ID = 1'b1;
        cyc("br_taken", BRT, 1'b0, 1'b0);

        // data-memory wait with a concurrent load-use
        clr();
        load_use_rs8();
        DmemReq_MEM = 1'b1; DmemReady = 1'b0;
        for (int i = 0; i < 3; i++) cyc("mem_wait", MEMST, 1'b0, 1'b0);
        DmemReady = 1'b1;
        cyc("mem_then_lu", STALL, 1'b0, 1'b0);
        clr();
        cyc("mem_done", NORM, 1'b0, 1'b0);

        // div, then mflo waits out the full divide latency
        MduOp_ID = 2'b10;
        cyc("div_start", NORM, 1'b1, 1'b0);
        MduOp_ID = 2'b11;
        for (int i = 1; i <= 32; i++) begin
            if (i == 5) begin
                DmemReq_MEM = 1'b1; DmemReady = 1'b0;
                cyc("div_memst", MEMST, 1'b0, 1'b1);
                DmemReq_MEM = 1'b0; DmemReady = 1'b1;
            end else begin
                cyc("div_busy", STALL, 1'b0, 1'b1);
            end
        end
        cyc("mflo_go", NORM, 1'b0, 1'b0);

        // mult held by load-use, then a second mult waits for the first
        clr();
        load_use_rs8();
        MduOp_ID = 2'b01;
        cyc("mul_suppr", STALL, 1'b0, 1'b0);
        clr();
        MduOp_ID = 2'b01;
        cyc("mul_start", NORM, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc("mul2_wait", STALL, 1'b0, 1'b1);
        cyc("mul2_start", NORM, 1'b1, 1'b0);
        MduOp_ID = 2'b00;
        for (int i = 0; i < 4; i++) cyc("mul2_busy", NORM, 1'b0, 1'b1);
        cyc("mul2_done", NORM, 1'b0, 1'b0);

        // reset in the middle of a divide
        MduOp_ID = 2'b10;
        cyc("rdiv_start", NORM, 1'b1, 1'b0);
        MduOp_ID = 2'b11;
        for (int i = 1; i <= 9; i++) cyc("rdiv_busy", STALL, 1'b0, 1'b1);
        rst_n = 1'b0;
        exp_stalls = 32'd0;
        push("rst_async", NORM, 1'b0, 1'b0);
        #1;
        check_pop();
        cyc("rst_hold", NORM, 1'b0, 1'b0);
        rst_n = 1'b1;
        MduOp_ID = 2'b01;
        cyc("rmul_start", NORM, 1'b1, 1'b0);
        MduOp_ID = 2'b00;
        for (int i = 0; i < 4; i++) cyc("rmul_busy", NORM, 1'b0, 1'b1);
        cyc("rmul_done", NORM, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=no_finish expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline; it sits beside the forwarding unit and covers the hazards forwarding cannot resolve. It detects load-use and branch-operand hazards, and owns the start/busy sequencing of the multi-cycle multiply/divide unit (MDU). It handles data-memory wait states and drives the write-enable and flush controls of the PC and the four pipeline registers. It also keeps a free-running stall-cycle counter for performance measurement.

## Interface
- MULT_CYCLES, 4, EX-to-result latency of mult/multu (≥1)
- DIV_CYCLES, 32, latency of div/divu (≥1)
- CNT_W, 6, MDU countdown width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- RegSource_ID / RegTarget_ID  in  5  rs/rt of ID instruction
- UsesRs_ID / UsesRt_ID  in  1  ID instruction reads rs/rt
- BranchOp_ID  in  1  ID instruction is branch/jr/jalr (operands consumed in ID)
- BranchTaken_ID  in  1  branch/jump resolved taken in ID
- MduOp_ID  in  2  00 none, 01 mult/multu, 10 div/divu, 11 mfhi/mflo/mthi/mtlo
- MemRead_EX / MemRead_MEM  in  3  load type, nonzero = load
- WriteRegAddr_EX / WriteRegAddr_MEM  in  5  destination registers
- DmemReq_MEM  in  1  load/store in MEM needs data memory
- DmemReady  in  1  data memory completes this cycle
- PcWrite, IfIdWrite, IdExWrite, ExMemWrite, MemWbWrite  out  1  register enables
- IfIdFlush, IdExFlush, MemWbFlush  out  1  insert bubble
- MduStart  out  1  one-cycle start to MDU
- MduBusy  out  1  MDU result not yet valid
- StallCycles  out  32  cycles with PcWrite=0

## Operation
- Hazard terms (combinational):
  - memStall = DmemReq_MEM & !DmemReady
  - mduStall = MduBusy & (MduOp_ID != 00)
  - loadUse = MemRead_EX!=0 & WriteRegAddr_EX!=0 & ((UsesRs_ID & rs==WriteRegAddr_EX) | (UsesRt_ID & rt==WriteRegAddr_EX))
  - brLoad = BranchOp_ID & MemRead_MEM!=0 & WriteRegAddr_MEM!=0 & rs/rt match WriteRegAddr_MEM
- Priority: memStall > mduStall > loadUse|brLoad > taken branch.
- memStall: all five write enables 0; MemWbFlush=1; no other flush.
- mduStall / loadUse / brLoad: PcWrite=IfIdWrite=0, IdExFlush=1; IdExWrite, ExMemWrite, MemWbWrite = 1.
- Taken branch with no stall: IfIdFlush=1, PcWrite=1. No delay slot.
- Otherwise: all enables 1, all flushes 0.
- MDU FSM states:
  - IDLE: MduStart=1 when MduOp_ID∈{01,10} and IdExWrite=1 and IdExFlush=0. Next state BUSY; count loads MULT_CYCLES or DIV_CYCLES.
  - BUSY: count decrements every cycle, including during memStall. On count==1, next state IDLE.
  - MduBusy=1 exactly in BUSY.
- An MDU op in ID while BUSY stalls; it starts on the first IDLE cycle in which it advances.
- StallCycles increments every cycle with PcWrite=0 and wraps 2^32−1 → 0.

## Timing
- All hazard outputs are combinational from the current inputs and state; no added latency.
- MduStart asserted in cycle T → MduBusy high T+1..T+N. An ID consumer stalled in those cycles advances at T+N+1.
- Reset values: FSM IDLE, count 0, StallCycles 0, MduBusy 0, MduStart 0. Hazard outputs are then input-driven.
- Reset mid-operation: rst_n low clears FSM, count and StallCycles asynchronously. MduBusy drops in the same cycle without waiting for clk.
- Simultaneous events:
  - MduStart is suppressed whenever any stall is active.
  - loadUse and BranchTaken_ID together → stall wins; the branch is re-resolved next cycle.
  - brLoad applies only while the load is still in MEM, so a branch after a load stalls 2 cycles total.
- Register 0 never creates a hazard.

## Structure
- Shared package holds:
  - MduOp_ID encodings (MDU_NONE, MDU_MUL, MDU_DIV, MDU_HILO)
  - MDU FSM state typedef (IDLE, BUSY)
  - default MULT_CYCLES / DIV_CYCLES
- One sub-module: mdu_sequencer (FSM + countdown, outputs MduBusy). Hazard detection and enable/flush logic stay in the top.

## Test plan
- lw $8 in EX, add using $8 in ID → one cycle of PcWrite=0, IfIdWrite=0, IdExFlush=1; StallCycles 0→1.
- beq $8 in ID, lw $8 in EX → stall 2 cycles (loadUse, then brLoad); resolves on cycle 3; StallCycles=2.
- div in ID at T, DIV_CYCLES=32, mflo follows → MduStart at T; MduBusy T+1..T+32; mflo stalled 32 cycles, advances at T+33.
- DmemReq_MEM=1, DmemReady=0 for 3 cycles with a simultaneous loadUse → all enables 0, MemWbFlush=1, IdExFlush=0 for 3 cycles; then a 1-cycle loadUse stall.
- BranchTaken_ID with no hazard → IfIdFlush=1, PcWrite=1. Same with loadUse active → IfIdFlush=0, IdExFlush=1.
- rst_n low at T+10 of a divide → MduBusy=0 and StallCycles=0 immediately. After release, a new mult starts cleanly with a MULT_CYCLES=4 busy window.
